// File: rtl/lcd_value_display_if.sv
//------------------------------------------------------------------------------
// Module   : lcd_value_display_if
// Brief    : HD44780 8-bit write-only bus between the display driver and panel.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface lcd_value_display_if;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [7:0] lcd_data;

    modport master (
        output lcd_rs,
        output lcd_rw,
        output lcd_e,
        output lcd_data
    );

    modport slave (
        input  lcd_rs,
        input  lcd_rw,
        input  lcd_e,
        input  lcd_data
    );
endinterface

`default_nettype wire

// File: rtl/lcd_value_display.sv
//------------------------------------------------------------------------------
// Module   : lcd_value_display
// Brief    : Initialises an HD44780 panel and shows a 4-bit value as two digits.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module lcd_value_display #(
    parameter int T_PWRUP = 1500000,
    parameter int T_CMD   = 4000,
    parameter int T_CLR   = 164000,
    parameter int T_SU    = 4,
    parameter int E_HIGH  = 30
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [3:0]                 value,
    output logic                       busy,
    lcd_value_display_if.master        lcd
);

    localparam int c_max_a = (T_PWRUP > T_CLR) ? T_PWRUP : T_CLR;
    localparam int c_max_b = (T_CMD > T_SU) ? T_CMD : T_SU;
    localparam int c_max_c = (c_max_b > E_HIGH) ? c_max_b : E_HIGH;
    localparam int c_max   = (c_max_a > c_max_c) ? c_max_a : c_max_c;
    localparam int c_cnt_w = $clog2(c_max + 1);

    localparam logic [c_cnt_w-1:0] c_pwrup_last = c_cnt_w'(T_PWRUP - 1);
    localparam logic [c_cnt_w-1:0] c_su_last    = c_cnt_w'(T_SU - 1);
    localparam logic [c_cnt_w-1:0] c_eh_last    = c_cnt_w'(E_HIGH - 1);
    localparam logic [c_cnt_w-1:0] c_cmd_last   = c_cnt_w'(T_CMD - 1);
    localparam logic [c_cnt_w-1:0] c_clr_last   = c_cnt_w'(T_CLR - 1);

    typedef enum logic [2:0] {
        S_PWRUP = 3'd0,
        S_INIT  = 3'd1,
        S_ADDR  = 3'd2,
        S_TENS  = 3'd3,
        S_ONES  = 3'd4,
        S_IDLE  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        P_SETUP = 2'd0,
        P_PULSE = 2'd1,
        P_WAIT  = 2'd2
    } phase_t;

    state_t               state_q, state_d;
    phase_t               phase_q, phase_d;
    logic [c_cnt_w-1:0]   cnt_q, cnt_d;
    logic [1:0]           idx_q, idx_d;
    logic [3:0]           shown_q, shown_d;
    logic                 rs_q, rs_d;
    logic [7:0]           data_q, data_d;
    logic                 e_q, e_d;
    logic                 busy_q, busy_d;
    logic                 w_start;
    logic [c_cnt_w-1:0]   w_wait_last;

    // {rs, data} for the byte a given state/step transmits.
    function automatic logic [8:0] f_byte(input state_t s, input logic [1:0] idx,
                                          input logic [3:0] shown);
        logic [3:0] ones;
        ones   = (shown >= 4'd10) ? (shown - 4'd10) : shown;
        f_byte = 9'h000;
        case (s)
            S_INIT: begin
                case (idx)
                    2'd0:    f_byte = {1'b0, 8'h38};
                    2'd1:    f_byte = {1'b0, 8'h0C};
                    2'd2:    f_byte = {1'b0, 8'h01};
                    default: f_byte = {1'b0, 8'h06};
                endcase
            end
            S_ADDR:  f_byte = {1'b0, 8'h80};
            S_TENS:  f_byte = {1'b1, 4'h3, 3'b000, (shown >= 4'd10)};
            S_ONES:  f_byte = {1'b1, 4'h3, ones};
            default: f_byte = 9'h000;
        endcase
    endfunction

    assign w_wait_last = ((state_q == S_INIT) && (idx_q == 2'd2)) ? c_clr_last : c_cmd_last;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        shown_d = shown_q;
        rs_d    = rs_q;
        data_d  = data_q;
        w_start = 1'b0;

        case (state_q)
            S_PWRUP: begin
                if (cnt_q == c_pwrup_last) begin
                    state_d = S_INIT;
                    idx_d   = 2'd0;
                    w_start = 1'b1;
                end
            end
            S_IDLE: begin
                cnt_d = '0;
                if (value != shown_q) begin
                    state_d = S_ADDR;
                    shown_d = value;
                    w_start = 1'b1;
                end
            end
            default: begin
                case (phase_q)
                    P_SETUP: begin
                        if (cnt_q == c_su_last) begin
                            phase_d = P_PULSE;
                            cnt_d   = '0;
                        end
                    end
                    P_PULSE: begin
                        if (cnt_q == c_eh_last) begin
                            phase_d = P_WAIT;
                            cnt_d   = '0;
                        end
                    end
                    default: begin
                        if (cnt_q == w_wait_last) begin
                            w_start = 1'b1;
                            case (state_q)
                                S_INIT: begin
                                    if (idx_q == 2'd3) begin
                                        // First update always happens, so latch here too.
                                        state_d = S_ADDR;
                                        shown_d = value;
                                    end else begin
                                        idx_d = idx_q + 2'd1;
                                    end
                                end
                                S_ADDR:  state_d = S_TENS;
                                S_TENS:  state_d = S_ONES;
                                default: begin
                                    state_d = S_IDLE;
                                    w_start = 1'b0;
                                    rs_d    = 1'b0;
                                    cnt_d   = '0;
                                end
                            endcase
                        end
                    end
                endcase
            end
        endcase

        if (w_start) begin
            phase_d          = P_SETUP;
            cnt_d            = '0;
            {rs_d, data_d}   = f_byte(state_d, idx_d, shown_d);
        end

        e_d    = (phase_d == P_PULSE) && (state_d != S_PWRUP) && (state_d != S_IDLE);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_PWRUP;
            phase_q <= P_SETUP;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            shown_q <= 4'd0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            e_q     <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shown_q <= shown_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            e_q     <= e_d;
            busy_q  <= busy_d;
        end
    end

    assign lcd.lcd_rs   = rs_q;
    assign lcd.lcd_rw   = 1'b0;
    assign lcd.lcd_e    = e_q;
    assign lcd.lcd_data = data_q;
    assign busy         = busy_q;

endmodule

`default_nettype wire
